// File: rtl/dpi_mem_bridge.sv
// dpi_mem_bridge: clocked, handshaked bridge from the core's fetch and
// load/store channels to the C memory model. One shared model port, one
// outstanding transaction, LATENCY-cycle response, length/alignment checks.

package dpi_mem_model_pkg;
  // Native stand-in for the C model so the bridge simulates without a C build.
  // Byte addressed, little endian, unwritten bytes read as zero. The call
  // counters let a bench see exactly how often the bridge touched the model.
  logic [7:0]  mem [longint unsigned];
  int unsigned ins_calls;
  int unsigned rd_calls;
  int unsigned wr_calls;
  int unsigned ebreak_calls;
  logic [7:0]  last_ebreak_flag;

  function automatic logic [7:0] rd_byte(input longint unsigned a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int unsigned readInsData(input longint unsigned addr, input int len);
    logic [31:0] v;
    v = '0;
    ins_calls = ins_calls + 1;
    for (int i = 0; i < 4; i++)
      if (i < len) v[8*i +: 8] = rd_byte(addr + 64'(i));
    return v;
  endfunction

  function automatic longint unsigned readMemData(input longint unsigned addr, input int len);
    logic [63:0] v;
    v = '0;
    rd_calls = rd_calls + 1;
    for (int i = 0; i < 8; i++)
      if (i < len) v[8*i +: 8] = rd_byte(addr + 64'(i));
    return v;
  endfunction

  function automatic void writeMemData(input longint unsigned addr, input longint unsigned data, input int len);
    logic [63:0] d;
    d = data;
    wr_calls = wr_calls + 1;
    for (int i = 0; i < 8; i++)
      if (i < len) mem[addr + 64'(i)] = d[8*i +: 8];
  endfunction

  function automatic void judgeIsEbreak(input byte unsigned flag);
    ebreak_calls = ebreak_calls + 1;
    last_ebreak_flag = flag;
  endfunction
endpackage

module dpi_mem_bridge #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int INST_W   = 32,
  parameter int LATENCY  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iEbreakFlag,
  input  logic              iInstReqValid,
  output logic              oInstReqReady,
  input  logic [ADDR_W-1:0] iInstReqAddr,
  output logic              oInstRespValid,
  input  logic              iInstRespReady,
  output logic [INST_W-1:0] oInstRespData,
  output logic              oInstRespErr,
  input  logic              iDataReqValid,
  output logic              oDataReqReady,
  input  logic              iDataReqWrEn,
  input  logic [ADDR_W-1:0] iDataReqAddr,
  input  logic [DATA_W-1:0] iDataReqWrData,
  input  logic [7:0]        iDataReqLen,
  output logic              oDataRespValid,
  input  logic              iDataRespReady,
  output logic [DATA_W-1:0] oDataRespRdData,
  output logic              oDataRespErr,
  output logic              oBusy,
  output logic              oEbreak
);
  import dpi_mem_model_pkg::*;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);
  localparam int unsigned MAX_LEN  = DATA_W / 8;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;     // 1 = data channel owns the transaction
  logic              rr_inst_q, rr_inst_d; // 1 = last grant went to fetch
  logic              inst_err_q, inst_err_d;
  logic              data_err_q, data_err_d;
  logic              ebreak_q, ebreak_d;
  logic [7:0]        prev_flag_q, prev_flag_d;
  logic [INST_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;

  logic              gnt_data, inst_acc, data_acc;
  logic              inst_misalign, len_pow2, data_illegal, ebreak_rise;
  logic [63:0]       inst_addr64, data_addr64, ld_mask;

  assign inst_addr64     = 64'(iInstReqAddr);
  assign data_addr64     = 64'(iDataReqAddr);
  assign inst_acc        = oInstReqReady;
  assign data_acc        = oDataReqReady;
  assign oInstRespData   = inst_rdata_q;
  assign oDataRespRdData = data_rdata_q;
  assign oInstRespErr    = inst_err_q;
  assign oDataRespErr    = data_err_q;
  assign oEbreak         = ebreak_q;

  // Grant: sole requester wins; on a tie, fixed data priority or alternate
  always_comb begin
    gnt_data = 1'b0;
    if (iDataReqValid && !iInstReqValid)
      gnt_data = 1'b1;
    else if (iDataReqValid && iInstReqValid)
      gnt_data = (ARB_MODE == 0) ? 1'b1 : rr_inst_q;
  end

  // Request legality and load byte mask
  always_comb begin
    inst_misalign = |iInstReqAddr[1:0];
    len_pow2      = 1'b0;
    ld_mask       = '1;
    case (iDataReqLen)
      8'd1: begin len_pow2 = 1'b1; ld_mask = 64'h0000_0000_0000_00FF; end
      8'd2: begin len_pow2 = 1'b1; ld_mask = 64'h0000_0000_0000_FFFF; end
      8'd4: begin len_pow2 = 1'b1; ld_mask = 64'h0000_0000_FFFF_FFFF; end
      8'd8: begin len_pow2 = 1'b1; ld_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      default: ;
    endcase
    data_illegal = !len_pow2 || (32'(iDataReqLen) > MAX_LEN) ||
                   ((data_addr64 & (64'(iDataReqLen) - 64'd1)) != 64'd0);
  end

  // Ebreak rising-edge detect, sticky until reset
  always_comb begin
    ebreak_rise = (|iEbreakFlag) && (prev_flag_q == 8'd0);
    ebreak_d    = ebreak_q | ebreak_rise;
    prev_flag_d = iEbreakFlag;
  end

  // FSM next state, latency counter, ownership, arbitration pointer, errors
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    rr_inst_d  = rr_inst_q;
    inst_err_d = inst_err_q;
    data_err_d = data_err_q;
    case (state_q)
      IDLE: if (inst_acc || data_acc) begin
        owner_d   = data_acc;
        rr_inst_d = inst_acc;
        if (inst_acc) inst_err_d = inst_misalign;
        else          data_err_d = data_illegal;
        if (LATENCY == 1) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: if (cnt_q <= 4'd1) begin
        state_d = RESP;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (owner_q ? iDataRespReady : iInstRespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: readies only in IDLE for the granted valid channel
  always_comb begin
    oInstReqReady = 1'b0;
    oDataReqReady = 1'b0;
    if (state_q == IDLE && !iReset) begin
      oInstReqReady = iInstReqValid && !gnt_data;
      oDataReqReady = iDataReqValid && gnt_data;
    end
    oInstRespValid = (state_q == RESP) && !owner_q;
    oDataRespValid = (state_q == RESP) && owner_q;
    oBusy          = (state_q != IDLE);
  end

  // State register
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      rr_inst_q   <= 1'b0;
      inst_err_q  <= 1'b0;
      data_err_q  <= 1'b0;
      ebreak_q    <= 1'b0;
      prev_flag_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      rr_inst_q   <= rr_inst_d;
      inst_err_q  <= inst_err_d;
      data_err_q  <= data_err_d;
      ebreak_q    <= ebreak_d;
      prev_flag_q <= prev_flag_d;
    end
  end

  // Model calls happen exactly once, at the accepting edge, so they live in a
  // clocked block; the payload they return is latched here and held until the
  // next acceptance, which keeps response data stable while valid is high.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (ebreak_rise) judgeIsEbreak(iEbreakFlag);
      if (inst_acc) begin
        if (inst_misalign) inst_rdata_q <= '0;
        else               inst_rdata_q <= INST_W'(readInsData(inst_addr64, 4));
      end
      if (data_acc) begin
        if (data_illegal) begin
          data_rdata_q <= '0;
        end else if (iDataReqWrEn) begin
          writeMemData(data_addr64, 64'(iDataReqWrData), int'(iDataReqLen));
          data_rdata_q <= '0;
        end else begin
          data_rdata_q <= DATA_W'(readMemData(data_addr64, int'(iDataReqLen)) & ld_mask);
        end
      end
    end
  end

endmodule
